// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, arrow codes and arrow mapping for the game scheduler.
// Macro ARROW_COMBO_EN widens the arrow mapping to lfsr[3:0] (codes 10..20).
package game_pkg;
    localparam int STATE_BITS      = 2;
    localparam int NUM_ARROWS_BITS = 5;
    localparam int RANDOM_BITS     = 6;
    typedef enum logic [STATE_BITS-1:0] {
        ST_GAME  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RESET = 2'd2
    } state_t;
    localparam logic [NUM_ARROWS_BITS-1:0] ARROW_BASE = 5'd10;
    localparam logic [NUM_ARROWS_BITS-1:0] ARROW_NONE = 5'd20;
    function automatic logic [NUM_ARROWS_BITS-1:0] arrow_map(input logic [RANDOM_BITS-1:0] v);
`ifdef ARROW_COMBO_EN
        return (v[3:0] <= 4'd10) ? ARROW_BASE + {1'b0, v[3:0]} : ARROW_NONE;
`else
        return (v[2:0] <= 3'd3) ? ARROW_BASE + {2'b0, v[2:0]} : ARROW_NONE;
`endif
    endfunction
endpackage

// File: rtl/arrow_lfsr.sv
// arrow_lfsr: 6-bit x^6+x^5+1 LFSR, shift left, stepped by i_step.
// Ports: clk, rst_n (async low), i_step; o_lfsr current value, o_next value after this edge.
module arrow_lfsr import game_pkg::*; #(
    parameter logic [RANDOM_BITS-1:0] SEED = 6'h2D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_step,
    output logic [RANDOM_BITS-1:0] o_lfsr,
    output logic [RANDOM_BITS-1:0] o_next
);
    localparam logic [RANDOM_BITS-1:0] SAFE_SEED = (SEED == '0) ? 6'h01 : SEED;
    logic [RANDOM_BITS-1:0] r_lfsr, w_shift;
    assign w_shift = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
    // all-zero lock-up guard
    assign o_next = !i_step ? r_lfsr : (|w_shift ? w_shift : 6'h01);
    assign o_lfsr = r_lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= SAFE_SEED;
        else        r_lfsr <= o_next;
    end
endmodule

// File: rtl/game_scheduler.sv
// game_scheduler: GAME/PAUSE/RESET FSM, tempo metronome and next-arrow generator.
// Ports: clk, rst_n (async low), btn_pause/btn_reset pulses, speed tempo select;
// state, metronome_clk beat wave, next_arrow code. Macro ARROW_COMBO_EN selects wide mapping.
module game_scheduler import game_pkg::*; #(
    parameter int                     HALF_PERIOD = 25_000_000,
    parameter logic [RANDOM_BITS-1:0] LFSR_SEED   = 6'h2D
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_pause,
    input  logic                       btn_reset,
    input  logic [1:0]                 speed,
    output logic [STATE_BITS-1:0]      state,
    output logic                       metronome_clk,
    output logic [NUM_ARROWS_BITS-1:0] next_arrow
);
    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] HP = CW'(HALF_PERIOD);
    state_t                 r_state, w_state_nxt;
    logic [1:0]             r_rst_cnt;
    logic [CW-1:0]          r_cnt, r_half, w_half_sel;
    logic                   w_toggle, w_fall, w_enter;
    logic [RANDOM_BITS-1:0] w_lfsr, w_lfsr_nxt;
    assign w_half_sel = ((HP >> speed) == '0) ? CW'(1) : (HP >> speed);
    // >= keeps the beat sane if a resample on resume shrinks the half-period below the count
    assign w_toggle = (r_state == ST_GAME) && (r_cnt >= r_half - CW'(1));
    assign w_fall   = w_toggle && metronome_clk && !btn_reset;
    assign w_enter  = (r_state == ST_PAUSE) && (w_state_nxt == ST_GAME);
    assign state    = r_state;
    always_comb begin
        w_state_nxt = r_state;
        if (btn_reset) w_state_nxt = ST_RESET;
        else if (r_state == ST_RESET) w_state_nxt = (r_rst_cnt == 2'd3) ? ST_PAUSE : ST_RESET;
        else if (btn_pause) w_state_nxt = (r_state == ST_GAME) ? ST_PAUSE : ST_GAME;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RESET;
            r_rst_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= (r_state == ST_RESET && !btn_reset) ? r_rst_cnt + 2'd1 : '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_half        <= CW'(1);
            metronome_clk <= 1'b0;
            next_arrow    <= ARROW_NONE;
        end else if (btn_reset) begin
            r_cnt         <= '0;
            metronome_clk <= 1'b0;
            next_arrow    <= ARROW_NONE;
        end else begin
            if (w_enter) r_half <= w_half_sel;
            if (w_toggle) begin
                r_cnt         <= '0;
                r_half        <= w_half_sel;
                metronome_clk <= ~metronome_clk;
            end else if (r_state == ST_GAME) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // arrow follows the freshly stepped LFSR, so it only moves on falling beats
            if (w_fall) next_arrow <= arrow_map(w_lfsr_nxt);
        end
    end
    arrow_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_fall),
        .o_lfsr (w_lfsr),
        .o_next (w_lfsr_nxt)
    );
endmodule
